// File: rtl/vec_operand_loader.sv
// Ping-pong operand loader: packs (x, k) pairs into C-lane banks and
// issues each full bank to vec_mul with a one-cycle enable strobe.
module vec_operand_loader #(
    parameter int C   = 16,
    parameter int W_X = 32,
    parameter int W_K = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [W_X-1:0]   s_x,
    input  logic [W_K-1:0]   s_k,
    input  logic             s_last,
    input  logic             hold,
    output logic [C*W_X-1:0] x,
    output logic [C*W_K-1:0] k,
    output logic             enable,
    output logic [15:0]      vec_count,
    output logic             busy
);

    localparam int LW = $clog2(C);

    typedef enum logic [1:0] {
        B_EMPTY   = 2'd0,
        B_FILLING = 2'd1,
        B_FULL    = 2'd2
    } bank_st_t;

    bank_st_t        st [2];
    logic [W_X-1:0]  bx [2][C];
    logic [W_K-1:0]  bk [2][C];
    logic            wr_bank;
    logic            rd_bank;
    logic [LW-1:0]   lane;
    logic [15:0]     cnt;
    logic            accept;
    logic            closing;

    assign s_ready   = (st[wr_bank] != B_FULL);
    assign accept    = s_valid && s_ready;
    assign closing   = accept && (s_last || lane == LW'(C - 1));
    assign enable    = (st[rd_bank] == B_FULL) && !hold;
    assign vec_count = cnt;
    assign busy      = (st[0] != B_EMPTY) || (st[1] != B_EMPTY);

    always_comb begin
        x = '0;
        k = '0;
        for (int i = 0; i < C; i++) begin
            x[i*W_X +: W_X] = bx[rd_bank][i];
            k[i*W_K +: W_K] = bk[rd_bank][i];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            lane    <= '0;
            cnt     <= '0;
            for (int b = 0; b < 2; b++) begin
                st[b] <= B_EMPTY;
                for (int i = 0; i < C; i++) begin
                    bx[b][i] <= '0;
                    bk[b][i] <= '0;
                end
            end
        end else begin
            if (enable) begin
                rd_bank <= ~rd_bank;
                cnt     <= cnt + 16'd1;
            end
            if (accept) begin
                lane <= closing ? '0 : lane + LW'(1);
                if (closing)
                    wr_bank <= ~wr_bank;
            end
            for (int b = 0; b < 2; b++) begin
                if (enable && rd_bank == 1'(b))
                    st[b] <= B_EMPTY;
                if (accept && wr_bank == 1'(b)) begin
                    st[b] <= closing ? B_FULL : B_FILLING;
                    // Lane-0 write wipes the rest so early-closed vectors pad with zero.
                    for (int i = 0; i < C; i++) begin
                        if (lane == LW'(i)) begin
                            bx[b][i] <= s_x;
                            bk[b][i] <= s_k;
                        end else if (lane == '0) begin
                            bx[b][i] <= '0;
                            bk[b][i] <= '0;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_vec_operand_loader.sv
// Self-checking bench for vec_operand_loader: table cases, corner
// sequences and random traffic against a two-entry vector queue model.
module tb_vec_operand_loader;

    localparam int C   = 16;
    localparam int W_X = 32;
    localparam int W_K = 32;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             s_valid = 1'b0;
    logic             s_last = 1'b0;
    logic             hold = 1'b0;
    logic [W_X-1:0]   s_x = '0;
    logic [W_K-1:0]   s_k = '0;
    logic             s_ready;
    logic             enable;
    logic             busy;
    logic [C*W_X-1:0] x;
    logic [C*W_K-1:0] k;
    logic [15:0]      vec_count;

    always #5 clk = ~clk;

    vec_operand_loader #(.C(C), .W_X(W_X), .W_K(W_K)) dut (
        .clk(clk), .rstn(rstn),
        .s_valid(s_valid), .s_ready(s_ready),
        .s_x(s_x), .s_k(s_k), .s_last(s_last),
        .hold(hold), .x(x), .k(k),
        .enable(enable), .vec_count(vec_count), .busy(busy)
    );

    typedef struct {
        logic [31:0] x [C];
        logic [31:0] k [C];
    } vec_t;

    typedef struct {
        int          n;
        int          last_at;
        bit          ramp;
        logic [31:0] xv;
        logic [31:0] kv;
        int          exp_vecs;
    } case_t;

    vec_t        vq [$];
    vec_t        cur;
    int          cur_n;
    logic [15:0] m_cnt;
    int          tests = 0;
    int          fails = 0;
    int          en_seen = 0;
    bit          last_en;

    function automatic void m_reset();
        vq.delete();
        cur_n = 0;
        m_cnt = '0;
        for (int i = 0; i < C; i++) begin
            cur.x[i] = '0;
            cur.k[i] = '0;
        end
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Called at a negedge with inputs set; returns at the next negedge.
    task automatic step(output bit acc);
        bit   m_rdy;
        bit   m_en;
        vec_t head;
        #1;
        m_rdy = (vq.size() < 2);
        m_en  = (vq.size() > 0) && !hold;
        chk("s_ready", 32'(s_ready), 32'(m_rdy));
        chk("enable", 32'(enable), 32'(m_en));
        chk("vec_count", 32'(vec_count), 32'(m_cnt));
        chk("busy", 32'(busy), 32'(vq.size() > 0 || cur_n > 0));
        last_en = enable;
        if (enable) en_seen++;
        if (m_en) begin
            head = vq[0];
            for (int i = 0; i < C; i++) begin
                chk("x_lane", x[i*W_X +: W_X], head.x[i]);
                chk("k_lane", k[i*W_K +: W_K], head.k[i]);
            end
        end
        acc = s_valid && m_rdy;
        @(posedge clk);
        if (m_en) begin
            void'(vq.pop_front());
            m_cnt++;
        end
        if (acc) begin
            cur.x[cur_n] = s_x;
            cur.k[cur_n] = s_k;
            cur_n++;
            if (s_last || cur_n == C) begin
                vq.push_back(cur);
                for (int i = 0; i < C; i++) begin
                    cur.x[i] = '0;
                    cur.k[i] = '0;
                end
                cur_n = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bit a;
        s_valid = 1'b0;
        s_last  = 1'b0;
        for (int i = 0; i < n; i++) step(a);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_enable"}, 32'(enable), 32'd0);
        chk({tag, "_s_ready"}, 32'(s_ready), 32'd1);
        chk({tag, "_x_zero"}, 32'(x == '0), 32'd1);
        chk({tag, "_k_zero"}, 32'(k == '0), 32'd1);
        chk({tag, "_vec_count"}, 32'(vec_count), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    case_t tbl [5];

    initial begin
        bit a;
        int j, guard, e0, acc_n, en_h, en_h1;

        tbl[0] = '{16, -1, 1'b1, 32'h0,        32'd2,        1};
        tbl[1] = '{64, -1, 1'b1, 32'h0,        32'd5,        4};
        tbl[2] = '{16, -1, 1'b0, 32'hFFFFFFFF, 32'h80000000, 1};
        tbl[3] = '{5,   4, 1'b0, 32'd7,        32'd7,        1};
        tbl[4] = '{21, 20, 1'b0, 32'd9,        32'd3,        2};

        @(negedge clk);
        @(negedge clk);
        #1;
        chk_reset_outputs("reset");
        m_reset();
        rstn = 1'b1;
        @(negedge clk);

        for (int t = 0; t < 5; t++) begin
            e0 = en_seen;
            j = 0;
            guard = 0;
            while (j < tbl[t].n && guard < 500) begin
                s_valid = 1'b1;
                s_x     = tbl[t].ramp ? 32'((j % C) + 1) : tbl[t].xv;
                s_k     = tbl[t].kv;
                s_last  = (j == tbl[t].last_at);
                step(a);
                if (a) j++;
                guard++;
            end
            chk("case_fed", 32'(j), 32'(tbl[t].n));
            idle(20);
            chk("case_vecs", 32'(en_seen - e0), 32'(tbl[t].exp_vecs));
        end

        // Backpressure: 48 offered under hold, only two banks' worth fit.
        hold  = 1'b1;
        acc_n = 0;
        e0    = en_seen;
        for (int c = 0; c < 48; c++) begin
            s_valid = 1'b1;
            s_x     = 32'(100 + acc_n);
            s_k     = 32'(acc_n);
            s_last  = 1'b0;
            step(a);
            if (a) acc_n++;
        end
        chk("bp_accepted", 32'(acc_n), 32'd32);
        #1;
        chk("bp_ready_low", 32'(s_ready), 32'd0);
        @(negedge clk);
        hold  = 1'b0;
        s_x   = 32'(100 + acc_n);
        s_k   = 32'(acc_n);
        step(a);
        en_h = last_en;
        if (a) acc_n++;
        s_x = 32'(100 + acc_n);
        s_k = 32'(acc_n);
        step(a);
        en_h1 = last_en;
        if (a) acc_n++;
        chk("bp_en_h", 32'(en_h), 32'd1);
        chk("bp_en_h1", 32'(en_h1), 32'd1);
        guard = 0;
        while (acc_n < 48 && guard < 100) begin
            s_valid = 1'b1;
            s_x     = 32'(100 + acc_n);
            s_k     = 32'(acc_n);
            step(a);
            if (a) acc_n++;
            guard++;
        end
        chk("bp_total", 32'(acc_n), 32'd48);
        idle(20);
        chk("bp_vecs", 32'(en_seen - e0), 32'd3);

        // Reset mid-fill: partial vector must vanish.
        acc_n = 0;
        guard = 0;
        e0    = en_seen;
        while (acc_n < 7 && guard < 50) begin
            s_valid = 1'b1;
            s_x     = 32'hDEAD0000 + 32'(acc_n);
            s_k     = 32'hBEEF0000 + 32'(acc_n);
            step(a);
            if (a) acc_n++;
            guard++;
        end
        s_valid = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        m_reset();
        @(negedge clk);
        rstn = 1'b1;
        idle(3);
        chk("midrst_no_enable", 32'(en_seen - e0), 32'd0);
        acc_n = 0;
        guard = 0;
        while (acc_n < 16 && guard < 50) begin
            s_valid = 1'b1;
            s_x     = 32'(acc_n * 3);
            s_k     = 32'(acc_n + 50);
            step(a);
            if (a) acc_n++;
            guard++;
        end
        idle(10);
        chk("midrst_vecs", 32'(en_seen - e0), 32'd1);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            s_valid = ($urandom_range(0, 3) != 0);
            hold    = ($urandom_range(0, 3) == 0);
            s_last  = ($urandom_range(0, 9) == 0);
            s_x     = $urandom;
            s_k     = $urandom;
            step(a);
        end
        hold = 1'b0;
        idle(40);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vec_operand_loader.md
# vec_operand_loader

Upstream feeder for `vec_mul`: accepts one (x, k) operand pair per cycle over a valid/ready stream and packs C pairs into a C-lane vector bank. It double-buffers two banks (ping-pong) so the stream can run continuously. It issues each full bank to `vec_mul` as packed `x`/`k` buses with a single-cycle `enable` pulse. Short vectors are closed early with `s_last` and zero-padded, so padded lanes contribute nothing to the dot product.

## Interface
Parameters:
- `C`, 16, lanes per vector (power of two, ≥2)
- `W_X`, 32, x element width
- `W_K`, 32, k element width

Ports:
- `clk`  in  1  clock, rising edge
- `rstn`  in  1  asynchronous active-low reset
- `s_valid`  in  1  operand pair valid
- `s_ready`  out  1  loader can accept a pair
- `s_x`  in  W_X  x element, signed, passed bit-exact
- `s_k`  in  W_K  k element, signed, passed bit-exact
- `s_last`  in  1  pair is the last of the current vector; close bank early
- `hold`  in  1  downstream cannot take a vector this cycle
- `x`  out  C*W_X  packed x vector to `vec_mul`; lane i at bits [i*W_X +: W_X]
- `k`  out  C*W_K  packed k vector, same lane layout
- `enable`  out  1  vector issue strobe to `vec_mul`
- `vec_count`  out  16  number of vectors issued, wraps modulo 2^16
- `busy`  out  1  some bank is FILLING or FULL

One clock (`clk`); reset `rstn` is asynchronous and active-low.

## Operation
- Two banks, each with state EMPTY, FILLING or FULL.
- Fill pointer `wr_bank`, lane counter `lane` (0..C-1), issue pointer `rd_bank`; all reset to 0.
- Bank transitions:
  - EMPTY→FILLING on acceptance into lane 0.
  - FILLING→FULL on acceptance into lane C-1, or on acceptance with `s_last`=1.
  - FULL→EMPTY on an issue.
- `s_ready` = bank[`wr_bank`] != FULL. It is derived from registered state only and does not depend on `s_valid` or `hold`.
- Accept: `s_valid && s_ready`.
  - The pair is written to lane `lane` of bank[`wr_bank`].
  - `lane` increments.
  - When the bank goes FULL: `lane`←0 and `wr_bank` toggles.
- Lane order: the first pair of a vector goes to lane 0.
- Zero padding: lanes not written in the current fill must read 0 when issued. This includes all lanes above the `s_last` lane and any stale data from an earlier vector.
- `s_last` on lane C-1 behaves the same as a normal completion.
- Issue: `enable` = bank[`rd_bank`]==FULL && !`hold`, combinational from registers and `hold`.
  - While `enable`=1, `x`/`k` present bank[`rd_bank`].
  - At that edge the bank becomes EMPTY, `rd_bank` toggles and `vec_count` increments.
- `x`/`k` always show bank[`rd_bank`]. Their value is meaningful only while `enable`=1.
- Simultaneous accept and issue in the same cycle are independent; both take effect.
- A bank that goes FULL while the other bank is FULL and not yet issued causes `s_ready`=0 until an issue frees the bank at `wr_bank`.

## Timing
- Reset values: `enable`=0, `s_ready`=1, `x`=0, `k`=0, `vec_count`=0, `busy`=0.
- Reset also clears both banks to EMPTY with zero contents.
- Reset mid-fill discards the partial vector; no `enable` is issued for it.
- Latency: the pair completing a bank is accepted in cycle t; `enable` is high in cycle t+1, given `hold`=0 and that bank is at `rd_bank`.
- `enable` is high for exactly one cycle per vector. Consecutive vectors can issue on consecutive cycles, for example after `hold` is released with both banks FULL.
- Throughput: with `hold`=0 and `s_valid` held at 1, `s_ready` never drops and one `enable` pulse occurs every C cycles.
- Backpressure: with `hold`=1, at most 2·C pairs are accepted. `s_ready` falls in the cycle after the second bank goes FULL.
- After `hold` falls in cycle h, `enable`=1 in cycle h. `s_ready` returns to 1 in cycle h+1.
- `vec_count` updates at the edge ending the `enable` cycle and wraps from 0xFFFF to 0x0000.

## Test plan
- **Single vector:** after reset, stream 16 pairs x=i+1, k=2 (i=0..15), `hold`=0. Required: `enable` for exactly one cycle, one cycle after the 16th accept; x lane i = i+1, k lane i = 2; `vec_count`=1.
- **Back-to-back:** 64 pairs with `s_valid` held at 1. Required: `s_ready` stays 1 throughout; 4 `enable` pulses spaced 16 cycles apart; `vec_count`=4.
- **Backpressure:** `hold`=1 while 48 pairs are offered. Required: exactly 32 accepted, then `s_ready`=0. Drop `hold`: two `enable` pulses on consecutive cycles, vector 0 first, then the remaining 16 pairs are accepted.
- **Early close:** `s_last` on the 5th pair (x=k=7 in every pair). Required: lanes 0..4 = 7 and lanes 5..15 = 0, even when the bank previously held nonzero data. The next pair lands in lane 0 of the other bank.
- **Reset mid-fill:** assert `rstn`=0 after 7 accepts. Required: all outputs at reset values, with no `enable`. Then 16 new pairs produce one clean vector containing no pre-reset data.
- **Sign pass-through:** x=0xFFFFFFFF, k=0x80000000 in all lanes. Required: bits on `x`/`k` are identical to the input, with no extension or truncation.
